// File: rtl/restoring_divider_16by8.sv
// Sequential unsigned restoring divider: 16-bit dividend / 8-bit divisor,
// one quotient bit per clock; results held until the next accepted operation.
module restoring_divider_16by8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    localparam int unsigned DVD_W = 16;
    localparam int unsigned DVS_W = 8;
    localparam int unsigned PR_W  = DVS_W + 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [DVD_W-1:0]   r_dvd;
    logic [DVS_W-1:0]   r_dvs;
    logic [PR_W-1:0]    r_pr;
    logic [CNT_W-1:0]   r_cnt;

    logic [PR_W-1:0]    w_t;
    logic               w_ge;
    logic [PR_W-1:0]    w_pr_next;
    logic [DVD_W-1:0]   w_dvd_next;

    // One restoring step; pr stays below the divisor, so its top bit drops out of t.
    // Quotient bits shift into the vacated low end of the dividend register.
    assign w_t        = PR_W'({r_pr, r_dvd[DVD_W-1]});
    assign w_ge       = (w_t >= {1'b0, r_dvs});
    assign w_pr_next  = w_ge ? (w_t - {1'b0, r_dvs}) : w_t;
    assign w_dvd_next = {r_dvd[DVD_W-2:0], w_ge};

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_pr        <= '0;
            r_cnt       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_dvd   <= dividend;
                            r_dvs   <= divisor;
                            r_pr    <= '0;
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend[DVS_W-1:0];
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    r_dvd <= w_dvd_next;
                    r_pr  <= w_pr_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Last step: publish directly from this step's results.
                    if (r_cnt == CNT_W'(DVD_W - 1)) begin
                        quotient    <= w_dvd_next;
                        remainder   <= w_pr_next[DVS_W-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/restoring_divider_16by8.md
# restoring_divider_16by8

Sequential unsigned restoring divider: 16-bit dividend divided by 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder at one quotient bit per clock. It is the inverse datapath of the 8-bit multiplier: its dividend port takes a 16-bit product directly, so a product can be divided by one of its operands to recover the other. Results are held stable for the seven-segment display path until the next accepted operation.

## Interface
Parameters: none (widths fixed at 16/8).

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- dividend  input  16  unsigned dividend; sampled on the accepted start
- divisor  input  8  unsigned divisor; sampled on the accepted start
- ready  output  1  high in IDLE; a start is accepted only then
- busy  output  1  high in CALC or DONE (equals not ready)
- done  output  1  one-cycle pulse; results are valid from this cycle
- quotient  output  16  registered quotient
- remainder  output  8  registered remainder
- div_by_zero  output  1  registered flag, set for a zero-divisor operation

## Operation
- States are IDLE, CALC and DONE.
- **IDLE**, start=1 and divisor≠0:
  - latch dividend into a 16-bit shift register and divisor into an 8-bit register;
  - clear the 9-bit partial remainder and the 4-bit iteration counter;
  - go to CALC.
- **IDLE**, start=1 and divisor=0: load quotient=16'hFFFF, remainder=dividend[7:0], div_by_zero=1, and go straight to DONE.
- **IDLE**, start=0: stay in IDLE; outputs hold.
- **CALC**, each cycle:
  - t = {pr[7:0], dvd[15]}, 9 bits;
  - shift dvd left by 1;
  - if t ≥ {1'b0, divisor}: pr = t − divisor and the new quotient LSB = 1;
  - else: pr = t and the new quotient LSB = 0.
- **CALC exit:** after 16 iterations (counter 15 → wrap), load the quotient/remainder output registers from the working registers, clear div_by_zero, and go to DONE.
- **Width rules:** the 9-bit t cannot overflow (max 2·255−1 = 509). The final pr is always < divisor, so remainder = pr[7:0] with no truncation loss. The quotient fits in 16 bits for every nonzero divisor.
- **DONE:** done=1 for exactly one cycle, then return to IDLE unconditionally. A start during DONE is ignored and is not queued.
- A start during CALC or DONE is ignored. Operand inputs are don't-care except in the accepting cycle.
- quotient, remainder and div_by_zero change only on CALC exit, on a zero-divisor acceptance, or on reset. They are never updated mid-calculation.

## Timing
- **Reset** (rst high at an edge):
  - state=IDLE; quotient=0, remainder=0, div_by_zero=0, done=0;
  - working registers and counter cleared;
  - ready=1 and busy=0 from the cycle after reset.
- rst has priority over start and over every state, including mid-CALC. An in-flight operation is abandoned and no done pulse is produced.
- **Normal latency:** start accepted at edge N; CALC occupies cycles N+1..N+16; done=1 and results valid in cycle N+17; ready=1 again in N+18. The earliest next accept is edge N+18, giving an 18-cycle initiation interval.
- **Zero divisor:** start accepted at edge N; done=1 and div_by_zero=1 in cycle N+1; ready=1 in N+2.
- ready and busy are decoded from state. done, quotient, remainder and div_by_zero are registered.
- No combinational path from any input to any output.

## Test plan
- 1000/7 (dividend=16'h03E8, divisor=8'h07) → quotient=142 (16'h008E), remainder=6, div_by_zero=0. done is a single pulse exactly 17 cycles after the accepting edge.
- 16'hFFFF/8'h01 → quotient=16'hFFFF, remainder=0. 16'hFFFF/8'hFF → quotient=257, remainder=0. 3/200 → quotient=0, remainder=3.
- 5/0 → div_by_zero=1, quotient=16'hFFFF, remainder=8'h05, done 1 cycle after acceptance. A following 10/3 → quotient=3, remainder=1, div_by_zero=0.
- **Start while busy:** accept 1000/7, then pulse start with 9/3 at N+5 and at N+17 (DONE). Only 142 r 6 is produced, there is exactly one done, and ready rises at N+18.
- **Reset mid-CALC:** assert rst at N+8. Next cycle: ready=1, quotient=0, remainder=0, div_by_zero=0, and no done pulse. A fresh 1000/7 then completes correctly.
- **Round trip:** 500 random (a, b), b≠0, with the dividend set to the 16-bit product a·b and the divisor set to b → quotient=a, remainder=0. Plus 500 random full-range operand pairs checked against the reference model's / and %.
